poly_eval_seq: RTL and testbench
================================

Name: poly_eval_seq

Overview:
- Iterative complex-polynomial evaluator: computes w = (z - r0)(z - r1)...(z - r(n-1)) for a programmable zero table of up to N_ZEROS entries.
- Time-shares one complex_sub and one complex_mult instance, one factor per clock.
- Sits between the pixel/coordinate generator (z source) and the colour-mapping stage (w sink).
- Replaces the fixed two-zero combinational evaluator when more zeros or runtime-configurable zeros are needed.

Parameters:
N_ZEROS, 8, depth of zero table (max polynomial degree); power of two, 2..16
AW, 3, zero-table address width = log2(N_ZEROS)
W, 16, component width of z, zeros, w (signed, same fixed-point format consumed by complex_mult)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  zero-table write strobe
cfg_addr  in  AW  zero-table index
cfg_re  in  W  zero real part
cfg_im  in  W  zero imaginary part
cfg_err  out  1  one-cycle pulse: write dropped because block was busy
n_zeros  in  AW+1  active zero count, sampled at accept
in_valid  in  1  z available
in_ready  out  1  block can accept z
z_re  in  W  input real
z_im  in  W  input imaginary
out_valid  out  1  result available
out_ready  in  1  sink accepts result
w_re  out  W  result real
w_im  out  W  result imaginary
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock clk; reset rst asynchronous, active-high. On reset: state=IDLE; zero table all (0,0); acc=(0,0); idx=0; in_ready=0 during reset, 1 from first clock after release; out_valid=0; w_re=w_im=0; cfg_err=0; busy=0.
- Reset asserted mid-computation aborts immediately. No result is emitted and the table is cleared.
- States:
  - IDLE: in_ready=1.
  - ACCUM: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Accept is in_valid && in_ready (IDLE only). On the accept edge:
  - latch z into z_reg
  - latch n = n_zeros; values 0 or >N_ZEROS clamp to 1 and N_ZEROS respectively
  - acc <= z - zero[0]
  - idx <= 1
  - next state = ACCUM if n>1, else DONE
- ACCUM: each cycle, acc <= complex_mult(acc, complex_sub(z_reg, zero[idx])) and idx <= idx+1. When idx == n-1, that update is the last and state -> DONE.
- Latency: out_valid rises on the n-th rising edge after the accept edge. n=1 gives 1 cycle; n=8 gives 8 cycles.
- Arithmetic: all wrap/truncation behaviour is exactly that of complex_sub and complex_mult. No extra rounding or saturation. Result is bit-exact to the sequential left-fold of those two modules.
- DONE: w_re/w_im = acc, held stable while out_valid && !out_ready (back-pressure). On out_valid && out_ready the block returns to IDLE; in_ready=1 the next cycle, so the minimum accept-to-accept interval is n+1 cycles. w retains its last value after the handshake.
- Zero-table writes:
  - Accepted only in IDLE; the write takes effect at that edge.
  - If a write and an accept occur in the same IDLE cycle, the write takes effect and the accept's zero[0] read sees the old value (read-before-write). Later factors see the new value.
  - cfg_we in ACCUM or DONE is dropped and cfg_err pulses high for exactly one cycle.
- Table entries are 2*W bits; out-of-range indices cannot occur because AW is sized to N_ZEROS.

Optional Feature:
- Macro POLY_EVAL_SEQ_CNT_EN.
- Defined: adds output port eval_count (32 bits). Reset to 0, increments by 1 on every out_valid && out_ready handshake, wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then write zero[0]=(0x0100,0x0000), zero[1]=(0x0000,0x0100), n_zeros=2, z=(0x0100,0x0000) -> out_valid on 2nd edge after accept, w=(0x0000,0x0000).
- Zeros all (0,0), n_zeros=1, z=(0x1234,0xFEDC) -> out_valid 1 cycle after accept, w=(0x1234,0xFEDC).
- n_zeros=8, random zeros and z -> out_valid exactly 8 cycles after accept; w matches golden left-fold of complex_sub/complex_mult; in_ready low throughout.
- Hold out_ready=0 for 5 cycles in DONE -> w stable, out_valid held, second in_valid ignored; raise out_ready -> IDLE, next z accepted the following cycle.
- cfg_we pulsed during ACCUM -> cfg_err one-cycle pulse, table unchanged (verified by re-evaluating with the same z). Write plus accept in the same cycle -> first result uses the old zero[0].
- Assert rst 3 cycles into an n=8 evaluation -> out_valid=0, busy=0, table cleared. With POLY_EVAL_SEQ_CNT_EN, eval_count=0 after reset and equals 3 after three completed handshakes.

Source files
------------

// File: rtl/poly_eval_seq.sv
// Iterative complex polynomial evaluator: w = prod (z - r[k]), one factor per clock.
// Optional `define POLY_EVAL_SEQ_CNT_EN adds a 32-bit eval_count handshake counter.

module complex_sub #(
   parameter int W = 16
) (
   input  logic [W-1:0] a_re,
   input  logic [W-1:0] a_im,
   input  logic [W-1:0] b_re,
   input  logic [W-1:0] b_im,
   output logic [W-1:0] d_re,
   output logic [W-1:0] d_im
);
   assign d_re = a_re - b_re;
   assign d_im = a_im - b_im;
endmodule

// Signed fixed point with FRAC fraction bits; products are floored, then wrapped to W.
module complex_mult #(
   parameter int W    = 16,
   parameter int FRAC = W / 2
) (
   input  logic [W-1:0] a_re,
   input  logic [W-1:0] a_im,
   input  logic [W-1:0] b_re,
   input  logic [W-1:0] b_im,
   output logic [W-1:0] p_re,
   output logic [W-1:0] p_im
);
   logic signed [2*W:0] ar, ai, br, bi, sr, si;

   always_comb begin
      ar = {{(W+1){a_re[W-1]}}, a_re};
      ai = {{(W+1){a_im[W-1]}}, a_im};
      br = {{(W+1){b_re[W-1]}}, b_re};
      bi = {{(W+1){b_im[W-1]}}, b_im};
      sr = ar * br - ai * bi;
      si = ar * bi + ai * br;
      p_re = W'(sr >>> FRAC);
      p_im = W'(si >>> FRAC);
   end
endmodule

module poly_eval_seq #(
   parameter int N_ZEROS = 8,
   parameter int AW      = 3,
   parameter int W       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [W-1:0]  cfg_re,
   input  logic [W-1:0]  cfg_im,
   output logic          cfg_err,
   input  logic [AW:0]   n_zeros,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  z_re,
   input  logic [W-1:0]  z_im,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  w_re,
   output logic [W-1:0]  w_im,
   output logic          busy
`ifdef POLY_EVAL_SEQ_CNT_EN
   ,
   output logic [31:0]   eval_count
`endif
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  tab_re_q [N_ZEROS];
   logic [W-1:0]  tab_im_q [N_ZEROS];
   logic [W-1:0]  zr_q, zi_q;
   logic [W-1:0]  acc_re_q, acc_im_q, acc_re_d, acc_im_d;
   logic [W-1:0]  w_re_q, w_im_q;
   logic [AW-1:0] idx_q, idx_d, rd_idx;
   logic [AW:0]   n_q, n_d, n_in;
   logic          init_q, err_q;
   logic          accept, last;
   logic [W-1:0]  sa_re, sa_im, f_re, f_im, p_re, p_im;

   always_comb begin
      n_in = n_zeros;
      if (n_zeros == '0)
         n_in = (AW+1)'(1);
      else if (n_zeros > (AW+1)'(N_ZEROS))
         n_in = (AW+1)'(N_ZEROS);
   end

   assign accept = in_valid && in_ready;
   assign last   = ({1'b0, idx_q} == n_q - 1'b1);

   // In IDLE the subtractor sees the live z and zero[0] so acc is ready at accept.
   assign rd_idx = (state_q == IDLE) ? '0 : idx_q;
   assign sa_re  = (state_q == IDLE) ? z_re : zr_q;
   assign sa_im  = (state_q == IDLE) ? z_im : zi_q;

   complex_sub #(.W(W)) u_sub (
      .a_re (sa_re),
      .a_im (sa_im),
      .b_re (tab_re_q[rd_idx]),
      .b_im (tab_im_q[rd_idx]),
      .d_re (f_re),
      .d_im (f_im)
   );

   complex_mult #(.W(W)) u_mul (
      .a_re (acc_re_q),
      .a_im (acc_im_q),
      .b_re (f_re),
      .b_im (f_im),
      .p_re (p_re),
      .p_im (p_im)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept)
               state_d = (n_in > (AW+1)'(1)) ? ACCUM : DONE;
         end
         ACCUM: begin
            if (last)
               state_d = DONE;
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE) && init_q;
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
   end

   always_comb begin
      acc_re_d = acc_re_q;
      acc_im_d = acc_im_q;
      idx_d    = idx_q;
      n_d      = n_q;
      if (accept) begin
         acc_re_d = f_re;
         acc_im_d = f_im;
         idx_d    = AW'(1);
         n_d      = n_in;
      end else if (state_q == ACCUM) begin
         acc_re_d = p_re;
         acc_im_d = p_im;
         idx_d    = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_ZEROS; i++) begin
            tab_re_q[i] <= '0;
            tab_im_q[i] <= '0;
         end
         zr_q     <= '0;
         zi_q     <= '0;
         acc_re_q <= '0;
         acc_im_q <= '0;
         w_re_q   <= '0;
         w_im_q   <= '0;
         idx_q    <= '0;
         n_q      <= '0;
         init_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         init_q   <= 1'b1;
         acc_re_q <= acc_re_d;
         acc_im_q <= acc_im_d;
         idx_q    <= idx_d;
         n_q      <= n_d;
         err_q    <= cfg_we && (state_q != IDLE);
         if (accept) begin
            zr_q <= z_re;
            zi_q <= z_im;
         end
         if (state_d == DONE && state_q != DONE) begin
            w_re_q <= acc_re_d;
            w_im_q <= acc_im_d;
         end
         if (cfg_we && state_q == IDLE) begin
            tab_re_q[cfg_addr] <= cfg_re;
            tab_im_q[cfg_addr] <= cfg_im;
         end
      end
   end

   assign w_re    = w_re_q;
   assign w_im    = w_im_q;
   assign cfg_err = err_q;

`ifdef POLY_EVAL_SEQ_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (out_valid && out_ready)
         cnt_q <= cnt_q + 32'd1;
   end

   assign eval_count = cnt_q;
`endif

endmodule

// File: tb/tb_poly_eval_seq.sv
// Scoreboard bench for poly_eval_seq: random zeros/z against an arithmetic fold model.
// Driver acts 1 time unit after rising edges; the monitor samples on falling edges.

module tb_poly_eval_seq;
   localparam int N  = 8;
   localparam int AW = 3;
   localparam int W  = 16;

   logic          clk = 0;
   logic          rst = 1;
   logic          cfg_we = 0;
   logic [AW-1:0] cfg_addr = 0;
   logic [W-1:0]  cfg_re = 0, cfg_im = 0;
   logic          cfg_err;
   logic [AW:0]   n_zeros = 0;
   logic          in_valid = 0, in_ready;
   logic [W-1:0]  z_re = 0, z_im = 0;
   logic          out_valid, out_ready = 1;
   logic [W-1:0]  w_re, w_im;
   logic          busy;
`ifdef POLY_EVAL_SEQ_CNT_EN
   logic [31:0]   eval_count;
`endif

   poly_eval_seq #(.N_ZEROS(N), .AW(AW), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_re    (cfg_re),
      .cfg_im    (cfg_im),
      .cfg_err   (cfg_err),
      .n_zeros   (n_zeros),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .z_re      (z_re),
      .z_im      (z_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .w_re      (w_re),
      .w_im      (w_im),
      .busy      (busy)
`ifdef POLY_EVAL_SEQ_CNT_EN
      ,
      .eval_count(eval_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] re;
      logic [15:0] im;
      int          n;
      int          acc;
   } exp_t;
   exp_t sb[$];

   logic [15:0] mre [N];
   logic [15:0] mim [N];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Q8.8 complex product, floor of the exact value, wrapped to 16 bits.
   function automatic void cmul(input logic signed [15:0] ar, ai, br, bi,
                                output logic [15:0] r, i);
      longint pr, pi;
      pr = longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
      pi = longint'(ar) * longint'(bi) + longint'(ai) * longint'(br);
      pr = pr >>> 8;
      pi = pi >>> 8;
      r = pr[15:0];
      i = pi[15:0];
   endfunction

   function automatic void fold(input logic [15:0] zr, zi, input int n,
                                output logic [15:0] rr, ri);
      logic [15:0] ar, ai, fr, fi, tr, ti;
      ar = zr - mre[0];
      ai = zi - mim[0];
      for (int k = 1; k < n; k++) begin
         fr = zr - mre[k];
         fi = zi - mim[k];
         cmul(ar, ai, fr, fi, tr, ti);
         ar = tr;
         ai = ti;
      end
      rr = ar;
      ri = ai;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic ov_prev = 0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         ov_prev = 0;
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               timeout("unexpected_out_valid");
            end else begin
               e = sb[0];
               chk("w_re", {16'h0, w_re}, {16'h0, e.re});
               chk("w_im", {16'h0, w_im}, {16'h0, e.im});
               if (!ov_prev)
                  chk("latency", cyc - e.acc + 1, e.n);
               if (out_ready)
                  void'(sb.pop_front());
            end
         end
         ov_prev = out_valid;
      end
   end

   task automatic cfg_write(input int a, input logic [15:0] re, im);
      cfg_we = 1;
      cfg_addr = AW'(a);
      cfg_re = re;
      cfg_im = im;
      step();
      cfg_we = 0;
      chk("cfg_err_idle", {31'h0, cfg_err}, 0);
      mre[a] = re;
      mim[a] = im;
   endtask

   // Holds in_valid until in_ready is seen, then predicts the result of that accept.
   task automatic send(input logic [15:0] zr, zi, input int nz);
      exp_t e;
      int k;
      int ne;
      in_valid = 1;
      z_re = zr;
      z_im = zi;
      n_zeros = (AW+1)'(nz);
      k = 0;
      while (!in_ready && k < 60) begin
         step();
         k++;
      end
      if (!in_ready) begin
         timeout("accept_wait");
         in_valid = 0;
         return;
      end
      ne = (nz == 0) ? 1 : (nz > N) ? N : nz;
      fold(zr, zi, ne, e.re, e.im);
      e.n = ne;
      e.acc = cyc + 1;
      sb.push_back(e);
      step();
      in_valid = 0;
      cfg_we = 0;
   endtask

   task automatic drain(input int stall);
      int k;
      out_ready = (stall == 0);
      k = 0;
      while (!out_valid && k < 40) begin
         chk("in_ready_busy", {30'h0, in_ready, busy}, 32'h1);
         step();
         k++;
      end
      if (!out_valid)
         timeout("out_valid_wait");
      repeat (stall) step();
      out_ready = 1;
      k = 0;
      while (sb.size() != 0 && k < 40) begin
         step();
         k++;
      end
      if (sb.size() != 0) begin
         timeout("drain");
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] zr, zi;
      for (int i = 0; i < N; i++) begin
         mre[i] = 0;
         mim[i] = 0;
      end
      #1;
      chk("rst_in_ready", {31'h0, in_ready}, 0);
      chk("rst_out_valid", {31'h0, out_valid}, 0);
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_cfg_err", {31'h0, cfg_err}, 0);
      chk("rst_w", {w_re, w_im}, 0);
      repeat (2) step();
      rst = 0;
      chk("in_ready_before_clk", {31'h0, in_ready}, 0);
`ifdef POLY_EVAL_SEQ_CNT_EN
      chk("eval_count_rst", eval_count, 0);
`endif
      step();
      chk("in_ready_after_clk", {31'h0, in_ready}, 1);

      cfg_write(0, 16'h0100, 16'h0000);
      cfg_write(1, 16'h0000, 16'h0100);
      send(16'h0100, 16'h0000, 2);
      drain(0);
      chk("t1_w_const", {w_re, w_im}, 32'h0000_0000);

      cfg_write(0, 16'h0000, 16'h0000);
      cfg_write(1, 16'h0000, 16'h0000);
      send(16'h1234, 16'hFEDC, 1);
      drain(0);
      chk("t2_w_const", {w_re, w_im}, 32'h1234_FEDC);

      for (int i = 0; i < N; i++)
         cfg_write(i, 16'($urandom), 16'($urandom));
      send(16'($urandom), 16'($urandom), 8);
      drain(0);

      // Back-pressure with a second z waiting; it must be taken right after the handshake.
      out_ready = 0;
      send(16'h0180, 16'hFF40, 3);
      in_valid = 1;
      z_re = 16'h0321;
      z_im = 16'h0055;
      n_zeros = 4'd2;
      while (!out_valid) step();
      repeat (5) begin
         chk("bp_out_valid", {31'h0, out_valid}, 1);
         chk("bp_in_ready", {31'h0, in_ready}, 0);
         step();
      end
      out_ready = 1;
      step();
      chk("bp_ready_next", {31'h0, in_ready}, 1);
      send(16'h0321, 16'h0055, 2);
      drain(0);

      // Write during ACCUM is dropped.
      zr = 16'($urandom);
      zi = 16'($urandom);
      send(zr, zi, 8);
      cfg_we = 1;
      cfg_addr = 3'd2;
      cfg_re = 16'h7777;
      cfg_im = 16'h1111;
      step();
      cfg_we = 0;
      chk("cfg_err_pulse", {31'h0, cfg_err}, 1);
      step();
      chk("cfg_err_clear", {31'h0, cfg_err}, 0);
      drain(0);
      send(zr, zi, 8);
      drain(0);

      // Same-cycle write and accept: first result uses the old zero[0].
      cfg_we = 1;
      cfg_addr = 3'd0;
      cfg_re = 16'h0200;
      cfg_im = 16'hFF00;
      send(16'h0100, 16'h0080, 3);
      mre[0] = 16'h0200;
      mim[0] = 16'hFF00;
      drain(1);
      send(16'h0100, 16'h0080, 3);
      drain(0);

      // Reset mid-evaluation.
      send(16'($urandom), 16'($urandom), 8);
      repeat (2) step();
      rst = 1;
      #1;
      chk("abort_out_valid", {31'h0, out_valid}, 0);
      chk("abort_busy", {31'h0, busy}, 0);
      chk("abort_in_ready", {31'h0, in_ready}, 0);
      sb.delete();
      for (int i = 0; i < N; i++) begin
         mre[i] = 0;
         mim[i] = 0;
      end
      repeat (2) step();
      rst = 0;
      step();
`ifdef POLY_EVAL_SEQ_CNT_EN
      chk("eval_count_abort", eval_count, 0);
`endif
      send(16'h0180, 16'h00C0, 8);
      drain(0);
      send(16'h0090, 16'hFFA0, 8);
      drain(0);
      send(16'h0101, 16'h0002, 5);
      drain(0);
`ifdef POLY_EVAL_SEQ_CNT_EN
      chk("eval_count_3", eval_count, 3);
`endif

      for (int t = 0; t < 25; t++) begin
         repeat ($urandom_range(0, 3))
            cfg_write($urandom_range(0, N - 1), 16'($urandom), 16'($urandom));
         send(16'($urandom), 16'($urandom), $urandom_range(0, 15));
         drain($urandom_range(0, 3));
      end

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
